pb_soc_bus_arbiter: RTL and testbench
=====================================

Name: pb_soc_bus_arbiter

Overview:
Two-master arbiter in front of the Picoblaze SOC register file bus (8-bit addr, 8-bit data, rd/wr strobes, combinational read data). Master 0 is the Picoblaze port and master 1 is the debug/loader port. The block serialises accesses with round-robin fairness and an optional bounded lock for atomic multi-register sequences. It issues exactly one single-cycle rd or wr strobe per granted request and returns registered read data with a one-cycle ack.

Parameters:
MAX_LOCK, 8, maximum consecutive locked grants to one master before the lock is ignored for one arbitration (range 1-255)

Ports:
clk_i  in  1  system clock
rst_n_i  in  1  asynchronous active-low reset
m0_req_i  in  1  master 0 request; held until m0_ack_o
m0_we_i  in  1  master 0 write (1) / read (0)
m0_lock_i  in  1  master 0 requests to keep ownership for its next access
m0_addr_i  in  8  master 0 register address
m0_wdata_i  in  8  master 0 write data
m0_ack_o  out  1  master 0 one-cycle completion pulse
m0_rdata_o  out  8  master 0 read data, valid while m0_ack_o=1
m1_req_i, m1_we_i, m1_lock_i, m1_addr_i, m1_wdata_i, m1_ack_o, m1_rdata_o  same as master 0, for master 1
addr_o  out  8  register-file address
data_o  out  8  register-file write data
rd_o  out  1  register-file read strobe
wr_o  out  1  register-file write strobe
data_i  in  8  register-file read data (combinational on rd_o/addr_o)
gnt_o  out  2  one-hot current owner (bit0=m0, bit1=m1); 00 when idle
busy_o  out  1  high in XFER and ACK states

Behaviour:
- Reset (async, rst_n_i=0): state=IDLE; all outputs 0; last_grant=1, so m0 wins the first tie; lock_cnt=0. Reset in XFER or ACK aborts the transfer: the strobe drops immediately and no ack is issued.
- All outputs are registered.
- FSM IDLE -> XFER -> ACK -> IDLE. Each access takes exactly 3 cycles. A request sampled in IDLE at edge T0 gives the strobe during T0..T1 and the ack during T1..T2.
- IDLE: winner selection on the sampled req lines:
  - Only one req high: that master wins.
  - Both high: the master not equal to last_grant wins.
  - Lock override: if the owner of the previous access had lock_i=1 when its ack was issued, its req is high, and lock_cnt<MAX_LOCK, that owner wins regardless.
  - On a win: load addr_o/data_o from the winner, assert wr_o=we or rd_o=~we, set gnt_o, and go to XFER.
  - No req high: stay in IDLE with gnt_o=00.
- XFER: the strobe is high for exactly this cycle.
  - At the exiting edge, capture data_i into the winner's rdata on reads; on writes rdata keeps its previous value.
  - Clear rd_o/wr_o, assert the winner's ack_o, update last_grant, and go to ACK.
- ACK: ack_o is high for exactly one cycle and req is ignored. At the exiting edge, deassert ack_o, clear gnt_o, and go to IDLE.
  - The master must drop or renew req in the cycle after ack. A req still high in IDLE is a new request.
- Lock counter:
  - lock_cnt increments at each ack granted via the lock override.
  - It resets to 0 when the owner's lock_i=0 at ack, when the other master wins, or when MAX_LOCK is reached. Reaching MAX_LOCK forces normal round-robin for the next arbitration.
- Addr/wdata/we from a non-granted master never reach the slave bus. Only the granted master ever sees ack_o.
- rd_o and wr_o are never high simultaneously. Neither is high outside XFER.

Test Plan:
- Single read: m0 reads addr 0x08 with data_i=0x5A during XFER -> rd_o high for exactly 1 cycle with addr_o=0x08; m0_ack_o pulses 2 cycles after req is sampled, with m0_rdata_o=0x5A; m1_ack_o stays 0.
- Single write: m1 writes 0x3C to 0xFF -> wr_o=1, addr_o=0xFF, data_o=0x3C for 1 cycle; gnt_o=10; m1_ack_o pulses; m1_rdata_o unchanged.
- Contention: both masters hold req continuously with lock=0 for 6 accesses -> grants alternate m0,m1,m0,m1,m0,m1, and each master sees 3 acks.
- Lock bound with MAX_LOCK=4: m0 holds req and lock=1 while m1 holds req -> grant order m0 x5 (one normal grant plus 4 locked), then m1, then m0 again.
- Reset mid-transfer: assert rst_n_i=0 during XFER of an m0 write -> wr_o falls asynchronously; no m0_ack_o; after release, state is IDLE with gnt_o=00, and a simultaneous m0/m1 req grants m0 first.

Source files
------------

// File: rtl/pb_soc_bus_arbiter.sv
// pb_soc_bus_arbiter
//   Two-master arbiter for the Picoblaze SOC register-file bus. Master 0 is
//   the Picoblaze port, master 1 the debug/loader port. Accesses are
//   serialised round-robin. A master may hold ownership across consecutive
//   accesses with lock_i, bounded to MAX_LOCK back-to-back locked grants.
//   Each access runs IDLE -> XFER (one rd/wr strobe) -> ACK (one ack pulse).
//
// Ports
//   clk_i, rst_n_i         clock, asynchronous active-low reset
//   mN_req_i               request, held until mN_ack_o
//   mN_we_i                1 = write, 0 = read
//   mN_lock_i              keep ownership for the next access
//   mN_addr_i, mN_wdata_i  register address / write data
//   mN_ack_o               one-cycle completion pulse
//   mN_rdata_o             read data, valid while mN_ack_o = 1
//   addr_o, data_o         register-file address / write data
//   rd_o, wr_o             register-file strobes (XFER only, never both)
//   data_i                 register-file read data (combinational)
//   gnt_o                  one-hot owner (bit0 = m0, bit1 = m1), 00 when idle
//   busy_o                 high in XFER and ACK
module pb_soc_bus_arbiter #(
  parameter int unsigned MAX_LOCK = 8
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic       m0_req_i,
  input  logic       m0_we_i,
  input  logic       m0_lock_i,
  input  logic [7:0] m0_addr_i,
  input  logic [7:0] m0_wdata_i,
  output logic       m0_ack_o,
  output logic [7:0] m0_rdata_o,
  input  logic       m1_req_i,
  input  logic       m1_we_i,
  input  logic       m1_lock_i,
  input  logic [7:0] m1_addr_i,
  input  logic [7:0] m1_wdata_i,
  output logic       m1_ack_o,
  output logic [7:0] m1_rdata_o,
  output logic [7:0] addr_o,
  output logic [7:0] data_o,
  output logic       rd_o,
  output logic       wr_o,
  input  logic [7:0] data_i,
  output logic [1:0] gnt_o,
  output logic       busy_o
);

  localparam logic [8:0] MAX_LOCK_W = 9'(MAX_LOCK);

  typedef enum logic [1:0] {S_IDLE, S_XFER, S_ACK} state_t;

  state_t     state, state_d;
  logic       last_grant, last_grant_d;
  logic [7:0] lock_cnt, lock_cnt_d;
  logic       lock_hold, lock_hold_d;   // previous owner had lock_i=1 at its ack
  logic       via_lock, via_lock_d;     // current grant came from the lock override

  logic [7:0] addr_d, data_d, rdata0_d, rdata1_d;
  logic       rd_d, wr_d, ack0_d, ack1_d, busy_d;
  logic [1:0] gnt_d;

  logic [1:0] req;
  logic       any_req, lock_win, win;
  logic       owner, owner_lock;
  logic [8:0] cnt_inc;

  // Winner selection on the sampled request lines.
  always_comb begin
    req      = {m1_req_i, m0_req_i};
    any_req  = |req;
    lock_win = lock_hold && req[last_grant] && ({1'b0, lock_cnt} < MAX_LOCK_W);
    if (lock_win)
      win = last_grant;
    else if (req == 2'b11)
      win = ~last_grant;
    else
      win = req[1];
  end

  // State register plus all registered outputs.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state      <= S_IDLE;
      last_grant <= 1'b1;
      lock_cnt   <= '0;
      lock_hold  <= 1'b0;
      via_lock   <= 1'b0;
      addr_o     <= '0;
      data_o     <= '0;
      rd_o       <= 1'b0;
      wr_o       <= 1'b0;
      gnt_o      <= '0;
      busy_o     <= 1'b0;
      m0_ack_o   <= 1'b0;
      m1_ack_o   <= 1'b0;
      m0_rdata_o <= '0;
      m1_rdata_o <= '0;
    end else begin
      state      <= state_d;
      last_grant <= last_grant_d;
      lock_cnt   <= lock_cnt_d;
      lock_hold  <= lock_hold_d;
      via_lock   <= via_lock_d;
      addr_o     <= addr_d;
      data_o     <= data_d;
      rd_o       <= rd_d;
      wr_o       <= wr_d;
      gnt_o      <= gnt_d;
      busy_o     <= busy_d;
      m0_ack_o   <= ack0_d;
      m1_ack_o   <= ack1_d;
      m0_rdata_o <= rdata0_d;
      m1_rdata_o <= rdata1_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = S_IDLE;
    case (state)
      S_IDLE:  state_d = any_req ? S_XFER : S_IDLE;
      S_XFER:  state_d = S_ACK;
      S_ACK:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Next values of the registered outputs and arbitration bookkeeping.
  always_comb begin
    addr_d       = addr_o;
    data_d       = data_o;
    rd_d         = 1'b0;
    wr_d         = 1'b0;
    gnt_d        = gnt_o;
    ack0_d       = 1'b0;
    ack1_d       = 1'b0;
    rdata0_d     = m0_rdata_o;
    rdata1_d     = m1_rdata_o;
    last_grant_d = last_grant;
    lock_cnt_d   = lock_cnt;
    lock_hold_d  = lock_hold;
    via_lock_d   = via_lock;
    busy_d       = (state_d != S_IDLE);
    owner        = gnt_o[1];
    owner_lock   = owner ? m1_lock_i : m0_lock_i;
    cnt_inc      = {1'b0, lock_cnt} + 9'd1;

    case (state)
      S_IDLE: begin
        if (any_req) begin
          gnt_d      = win ? 2'b10 : 2'b01;
          addr_d     = win ? m1_addr_i  : m0_addr_i;
          data_d     = win ? m1_wdata_i : m0_wdata_i;
          wr_d       = win ? m1_we_i    : m0_we_i;
          rd_d       = win ? ~m1_we_i   : ~m0_we_i;
          via_lock_d = lock_win;
        end else begin
          gnt_d = 2'b00;
        end
      end
      S_XFER: begin
        if (rd_o) begin
          if (owner) rdata1_d = data_i;
          else       rdata0_d = data_i;
        end
        if (owner) ack1_d = 1'b1;
        else       ack0_d = 1'b1;
        last_grant_d = owner;
        // A locked grant that reaches the bound drops the hold so the next
        // arbitration is plain round-robin; a normal grant restarts counting.
        if (owner_lock && via_lock) begin
          if (cnt_inc >= MAX_LOCK_W) begin
            lock_cnt_d  = '0;
            lock_hold_d = 1'b0;
          end else begin
            lock_cnt_d  = cnt_inc[7:0];
            lock_hold_d = 1'b1;
          end
        end else begin
          lock_cnt_d  = '0;
          lock_hold_d = owner_lock;
        end
      end
      S_ACK: begin
        gnt_d = 2'b00;
      end
      default: begin
        gnt_d = 2'b00;
      end
    endcase
  end

endmodule

// File: tb/tb_pb_soc_bus_arbiter.sv
module tb_pb_soc_bus_arbiter;

  localparam int unsigned MAXL = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       m0_req, m0_we, m0_lock, m0_ack;
  logic [7:0] m0_addr, m0_wdata, m0_rdata;
  logic       m1_req, m1_we, m1_lock, m1_ack;
  logic [7:0] m1_addr, m1_wdata, m1_rdata;
  logic [7:0] addr_o, data_o, data_i;
  logic       rd_o, wr_o, busy_o;
  logic [1:0] gnt_o;

  logic [7:0] rf [256];

  always #5 clk = ~clk;

  assign data_i = rf[addr_o];

  pb_soc_bus_arbiter #(.MAX_LOCK(MAXL)) dut (
    .clk_i(clk), .rst_n_i(rst_n),
    .m0_req_i(m0_req), .m0_we_i(m0_we), .m0_lock_i(m0_lock),
    .m0_addr_i(m0_addr), .m0_wdata_i(m0_wdata), .m0_ack_o(m0_ack), .m0_rdata_o(m0_rdata),
    .m1_req_i(m1_req), .m1_we_i(m1_we), .m1_lock_i(m1_lock),
    .m1_addr_i(m1_addr), .m1_wdata_i(m1_wdata), .m1_ack_o(m1_ack), .m1_rdata_o(m1_rdata),
    .addr_o(addr_o), .data_o(data_o), .rd_o(rd_o), .wr_o(wr_o), .data_i(data_i),
    .gnt_o(gnt_o), .busy_o(busy_o)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic       r0, w0, l0;
    logic [7:0] a0, d0;
    logic       r1, w1, l1;
    logic [7:0] a1, d1;
    logic [1:0] gnt;
    logic       rd, wr;
    logic [7:0] addr, data;
    logic       ack0, ack1;
    logic [7:0] rdat0, rdat1;
    logic       busy;
  } vec_t;

  vec_t tbl [13];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    m0_req = 0; m0_we = 0; m0_lock = 0; m0_addr = '0; m0_wdata = '0;
    m1_req = 0; m1_we = 0; m1_lock = 0; m1_addr = '0; m1_wdata = '0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle_inputs();
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_gnt"},  32'(gnt_o),  32'h0);
    chk({tag, "_rd"},   32'(rd_o),   32'h0);
    chk({tag, "_wr"},   32'(wr_o),   32'h0);
    chk({tag, "_busy"}, 32'(busy_o), 32'h0);
    chk({tag, "_ack0"}, 32'(m0_ack), 32'h0);
    chk({tag, "_ack1"}, 32'(m1_ack), 32'h0);
  endtask

  // Runs both masters with held requests for ncyc cycles and records grant order.
  int gseq [8];
  int ng, nack0, nack1, both_strobe;

  task automatic run_contention(input int ncyc);
    ng = 0; nack0 = 0; nack1 = 0; both_strobe = 0;
    for (int c = 0; c < ncyc; c++) begin
      step();
      if (rd_o && wr_o) both_strobe++;
      if ((rd_o || wr_o) && ng < 8) begin
        gseq[ng] = gnt_o[1] ? 1 : 0;
        ng++;
      end
      if (m0_ack) nack0++;
      if (m1_ack) nack1++;
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) rf[i] = '0;
    rf[8'h08] = 8'h5A;
    rf[8'h10] = 8'h11;
    rf[8'h20] = 8'h22;
    rf[8'hFF] = 8'hA7;
    rf[8'h40] = 8'h33;

    //          m0: r w l addr    wdata    m1: r w l addr    wdata    gnt   rd wr addr    data    a0 a1 rdata0  rdata1  busy
    tbl[0]  = '{1,0,0,8'h08,8'h00, 0,0,0,8'h00,8'h00, 2'b01,1,0,8'h08,8'h00,0,0,8'h00,8'h00,1};
    tbl[1]  = '{1,0,0,8'h08,8'h00, 0,0,0,8'h00,8'h00, 2'b01,0,0,8'h08,8'h00,1,0,8'h5A,8'h00,1};
    tbl[2]  = '{0,0,0,8'h00,8'h00, 0,0,0,8'h00,8'h00, 2'b00,0,0,8'h08,8'h00,0,0,8'h5A,8'h00,0};
    tbl[3]  = '{0,0,0,8'h00,8'h00, 1,1,0,8'hFF,8'h3C, 2'b10,0,1,8'hFF,8'h3C,0,0,8'h5A,8'h00,1};
    tbl[4]  = '{0,0,0,8'h00,8'h00, 1,1,0,8'hFF,8'h3C, 2'b10,0,0,8'hFF,8'h3C,0,1,8'h5A,8'h00,1};
    tbl[5]  = '{0,0,0,8'h00,8'h00, 0,0,0,8'h00,8'h00, 2'b00,0,0,8'hFF,8'h3C,0,0,8'h5A,8'h00,0};
    tbl[6]  = '{0,0,0,8'h00,8'h00, 0,0,0,8'h00,8'h00, 2'b00,0,0,8'hFF,8'h3C,0,0,8'h5A,8'h00,0};
    tbl[7]  = '{1,0,0,8'h10,8'h00, 1,0,0,8'h20,8'h99, 2'b01,1,0,8'h10,8'h00,0,0,8'h5A,8'h00,1};
    tbl[8]  = '{1,0,0,8'h10,8'h00, 1,0,0,8'h20,8'h99, 2'b01,0,0,8'h10,8'h00,1,0,8'h11,8'h00,1};
    tbl[9]  = '{1,0,0,8'h10,8'h00, 1,0,0,8'h20,8'h99, 2'b00,0,0,8'h10,8'h00,0,0,8'h11,8'h00,0};
    tbl[10] = '{1,0,0,8'h10,8'h00, 1,0,0,8'h20,8'h99, 2'b10,1,0,8'h20,8'h99,0,0,8'h11,8'h00,1};
    tbl[11] = '{1,0,0,8'h10,8'h00, 1,0,0,8'h20,8'h99, 2'b10,0,0,8'h20,8'h99,0,1,8'h11,8'h22,1};
    tbl[12] = '{0,0,0,8'h00,8'h00, 0,0,0,8'h00,8'h00, 2'b00,0,0,8'h20,8'h99,0,0,8'h11,8'h22,0};

    // Reset state
    do_reset();
    chk_idle_outputs("reset");
    chk("reset_addr",   32'(addr_o),   32'h0);
    chk("reset_data",   32'(data_o),   32'h0);
    chk("reset_rdata0", 32'(m0_rdata), 32'h0);
    chk("reset_rdata1", 32'(m1_rdata), 32'h0);

    // Table: single read, single write, one contended pair
    for (int v = 0; v < 13; v++) begin
      m0_req = tbl[v].r0; m0_we = tbl[v].w0; m0_lock = tbl[v].l0;
      m0_addr = tbl[v].a0; m0_wdata = tbl[v].d0;
      m1_req = tbl[v].r1; m1_we = tbl[v].w1; m1_lock = tbl[v].l1;
      m1_addr = tbl[v].a1; m1_wdata = tbl[v].d1;
      step();
      chk($sformatf("v%0d_gnt", v),    32'(gnt_o),    32'(tbl[v].gnt));
      chk($sformatf("v%0d_rd", v),     32'(rd_o),     32'(tbl[v].rd));
      chk($sformatf("v%0d_wr", v),     32'(wr_o),     32'(tbl[v].wr));
      chk($sformatf("v%0d_addr", v),   32'(addr_o),   32'(tbl[v].addr));
      chk($sformatf("v%0d_data", v),   32'(data_o),   32'(tbl[v].data));
      chk($sformatf("v%0d_ack0", v),   32'(m0_ack),   32'(tbl[v].ack0));
      chk($sformatf("v%0d_ack1", v),   32'(m1_ack),   32'(tbl[v].ack1));
      chk($sformatf("v%0d_rdata0", v), 32'(m0_rdata), 32'(tbl[v].rdat0));
      chk($sformatf("v%0d_rdata1", v), 32'(m1_rdata), 32'(tbl[v].rdat1));
      chk($sformatf("v%0d_busy", v),   32'(busy_o),   32'(tbl[v].busy));
    end

    // Contention without lock: strict alternation starting with m0
    do_reset();
    m0_req = 1; m0_addr = 8'h10;
    m1_req = 1; m1_addr = 8'h20;
    run_contention(18);
    chk("rr_count", 32'(ng), 32'd6);
    for (int i = 0; i < 6; i++)
      chk($sformatf("rr_grant%0d", i), 32'(gseq[i]), 32'(i % 2));
    chk("rr_acks0", 32'(nack0), 32'd3);
    chk("rr_acks1", 32'(nack1), 32'd3);
    chk("rr_excl",  32'(both_strobe), 32'd0);

    // Lock bound (MAX_LOCK=4): m0 x5, then m1, then m0
    do_reset();
    m0_req = 1; m0_lock = 1; m0_addr = 8'h08;
    m1_req = 1; m1_lock = 0; m1_addr = 8'h20;
    run_contention(21);
    chk("lk_count", 32'(ng), 32'd7);
    for (int i = 0; i < 7; i++)
      chk($sformatf("lk_grant%0d", i), 32'(gseq[i]), (i == 5) ? 32'd1 : 32'd0);
    chk("lk_excl", 32'(both_strobe), 32'd0);

    // Reset during the XFER of an m0 write
    do_reset();
    m0_req = 1; m0_we = 1; m0_addr = 8'h40; m0_wdata = 8'h77;
    step();
    chk("rx_wr_before", 32'(wr_o), 32'h1);
    chk("rx_gnt_before", 32'(gnt_o), 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rx_wr_async", 32'(wr_o), 32'h0);
    chk("rx_ack_async", 32'(m0_ack), 32'h0);
    step();
    chk_idle_outputs("rx_hold");
    idle_inputs();
    rst_n = 1'b1;
    step();
    chk_idle_outputs("rx_after");
    m0_req = 1; m0_addr = 8'h10;
    m1_req = 1; m1_addr = 8'h20;
    step();
    chk("rx_first_gnt", 32'(gnt_o), 32'h1);
    chk("rx_first_rd",  32'(rd_o),  32'h1);
    step();
    chk("rx_first_ack0",   32'(m0_ack),   32'h1);
    chk("rx_first_rdata0", 32'(m0_rdata), 32'h11);
    idle_inputs();
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
